// File: rtl/matrix_mult_sequencer.sv
// Sequential matrix multiplier: one 8x8 MAC per cycle, streams C(i,j) row-major over a valid/ready port.
// Optional busy-cycle counter enabled by defining MMSEQ_CYCLE_CNT_EN.
module matrix_mult_sequencer #(
   parameter int aRow = 5,
   parameter int aCol = 5,
   parameter int bRow = 5,
   parameter int bCol = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [aRow*aCol*8-1:0]   a,
   input  logic [bRow*bCol*8-1:0]   b,
   output logic                     busy,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [31:0]              res,
   output logic [7:0]               res_row,
   output logic [7:0]               res_col,
   output logic                     done,
   output logic [15:0]              cycle_cnt
);

   localparam int A_N = aRow * aCol;
   localparam int B_N = bRow * bCol;

   if (aCol != bRow || aRow < 1 || aRow > 255 || aCol < 1 || aCol > 255 ||
       bRow < 1 || bRow > 255 || bCol < 1 || bCol > 255) begin : g_param_check
      $error("matrix_mult_sequencer: illegal matrix dimensions");
   end

   // Result port handshake: an element transfers on a rising edge where
   // res_valid and res_ready are both high; res/res_row/res_col hold until then.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [A_N*8-1:0] a_q;
   logic [B_N*8-1:0] b_q;
   logic [7:0]       i;
   logic [7:0]       j;
   logic [7:0]       k;
   logic [31:0]      acc;
   logic [7:0]       a_el;
   logic [7:0]       b_el;
   logic [15:0]      prod;
   logic             last_i;
   logic             last_j;
   logic             last_k;

   // Element (r,c) lives at byte R*C-1-(r*C+c), so (0,0) is the top byte.
   always_comb begin
      a_el = a_q[(A_N - 1 - (int'(i) * aCol + int'(k))) * 8 +: 8];
      b_el = b_q[(B_N - 1 - (int'(k) * bCol + int'(j))) * 8 +: 8];
      prod = 16'(a_el) * 16'(b_el);
   end

   assign last_i = (i == 8'(aRow - 1));
   assign last_j = (j == 8'(bCol - 1));
   assign last_k = (k == 8'(aCol - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = MAC;
         MAC:  if (last_k) state_nxt = OUT;
         OUT:  if (res_ready) state_nxt = (last_i && last_j) ? DONE : MAC;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q <= '0;
         b_q <= '0;
         i   <= '0;
         j   <= '0;
         k   <= '0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q <= a;
                  b_q <= b;
                  i   <= '0;
                  j   <= '0;
                  k   <= '0;
                  acc <= '0;
               end
            end
            MAC: begin
               acc <= acc + 32'(prod);
               k   <= k + 8'd1;
            end
            OUT: begin
               if (res_ready) begin
                  acc <= '0;
                  k   <= '0;
                  // Indices wrap to zero after the final element so they never leave the matrix.
                  if (last_j) begin
                     j <= '0;
                     i <= last_i ? 8'd0 : i + 8'd1;
                  end else begin
                     j <= j + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign res_valid = (state == OUT);
   assign done      = (state == DONE);
   assign res       = acc;
   assign res_row   = i;
   assign res_col   = j;

`ifdef MMSEQ_CYCLE_CNT_EN
   logic [15:0] cnt_q;

   // Cleared on an accepted start, saturating, frozen while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (state == IDLE) begin
         if (start) cnt_q <= '0;
      end else if (cnt_q != 16'hFFFF) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign cycle_cnt = cnt_q;
`else
   assign cycle_cnt = '0;
`endif

endmodule

// File: doc/matrix_mult_sequencer.md
MATRIX_MULT_SEQUENCER -- requirements
Module: matrix_mult_sequencer

Interface
REQ-001 The module SHALL have these parameters: aRow, default 5, rows of matrix A.
REQ-002 aCol, default 5, columns of A; the module SHALL require aCol equal to bRow.
REQ-003 bRow, default 5, rows of matrix B.
REQ-004 bCol, default 5, columns of B; all four parameters SHALL be 1..255.
REQ-005 The module SHALL have these ports, each as name, direction, width, meaning: clk, in, 1, single clock, rising edge.
REQ-006 rst, in, 1, asynchronous active-low reset.
REQ-007 start, in, 1, request one multiply.
REQ-008 a, in, aRow*aCol*8, packed A, unsigned bytes.
REQ-009 b, in, bRow*bCol*8, packed B, unsigned bytes.
REQ-010 busy, out, 1, high in any state except IDLE.
REQ-011 res_valid, out, 1, res holds a valid element.
REQ-012 res_ready, in, 1, consumer accepts res.
REQ-013 res, out, 32, result element C(i,j).
REQ-014 res_row, out, 8, row index i of res.
REQ-015 res_col, out, 8, column index j of res.
REQ-016 done, out, 1, one-cycle pulse after the last element is accepted.
REQ-017 cycle_cnt, out, 16, busy-cycle count; see Configuration.

Function
REQ-018 For an R x C matrix M, element (r,c) SHALL sit at bits [(R*C-1-(r*C+c))*8 +: 8], so element (0,0) is the most significant byte.
REQ-019 The FSM SHALL have four states: IDLE, MAC, OUT and DONE.
REQ-020 In IDLE, start=1 at a rising edge SHALL latch a and b, clear the accumulator and set i=j=k=0, then go to MAC.
REQ-021 In MAC, each edge SHALL add A(i,k)*B(k,j) to the accumulator and increment k; the edge that adds the k=aCol-1 product SHALL go to OUT.
REQ-022 In OUT, res_valid SHALL be 1; res, res_row and res_col SHALL stay stable until an edge with res_valid and res_ready both high.
REQ-023 When that handshake edge occurs, the module SHALL advance j; when j wraps it SHALL advance i.
REQ-024 After the handshake, if another element remains, the module SHALL clear the accumulator and k and go to MAC.
REQ-025 After the handshake on the last element (aRow-1, bCol-1), the module SHALL go to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-027 Latency: res_valid SHALL rise aCol cycles after the start edge; with res_ready held high, each element SHALL take aCol+1 cycles.
REQ-028 Elements SHALL be emitted in row-major order.
REQ-029 start SHALL be ignored whenever busy=1, and latched operands SHALL not change mid-operation.
REQ-030 Products SHALL be 16-bit unsigned; the accumulator SHALL be 32-bit unsigned and cannot overflow for legal parameters.
REQ-031 res_ready while res_valid=0 SHALL have no effect.
REQ-032 start asserted in the same cycle as done SHALL be ignored; a new start SHALL be accepted from IDLE only.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, at any time including mid-operation, and discard the partial result.
REQ-034 During reset, busy, res_valid, res, res_row, res_col, done and cycle_cnt SHALL all be 0.
REQ-035 Operation SHALL resume on the first edge after rst returns to 1.

Configuration
REQ-036 With macro MMSEQ_CYCLE_CNT_EN defined, cycle_cnt SHALL clear when start is accepted and then increment each cycle spent outside IDLE.
REQ-037 With the macro defined, cycle_cnt SHALL saturate at 16'hFFFF and hold its value in IDLE until the next accepted start.
REQ-038 Without the macro, cycle_cnt SHALL be constant 0 and no counter logic SHALL be built; the port list SHALL be unchanged.

Verification
REQ-039 Defaults: A = B = five rows of {1,2,3,4,5}, start pulse, res_ready=1 -> 25 elements in row-major order with res = 15*(j+1) (15,30,45,60,75 per row), then done; cycle_cnt=151 with the macro defined.
REQ-040 Same stimulus with res_ready=0 for the first 3 cycles of res_valid -> res=15, res_row=0 and res_col=0 stay stable; then accepted; cycle_cnt=154.
REQ-041 All operand bytes 255 -> every res = 325125 (0x0004F605).
REQ-042 start re-pulsed during MAC with different a -> ignored; results equal those for the first operands.
REQ-043 rst=0 during the third element's MAC -> all outputs 0 at once; a fresh start then yields the full correct sequence from (0,0).
REQ-044 Build without MMSEQ_CYCLE_CNT_EN -> cycle_cnt=0 throughout the REQ-039 run; all other results unchanged.
